display_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the common-anode seven-segment display bank. It replaces the free-running divider and toggle with a sequenced scan. It cycles through the enabled digits, drives the digit-select index to the switch mux and the active-low PNP anode drives, and inserts a blanking interval between digits to suppress ghosting. It also emits a one-cycle frame tick per complete scan.

---
 rtl/display_scan_ctrl_if.sv | 12 +
 rtl/display_scan_ctrl.sv | 81 ++++++++
 tb/tb_display_scan_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit enables into the scanner; digit index, anode drives and frame tick out
interface display_scan_ctrl_if #(
   parameter int NUM_DIGITS = 2,
   parameter int SEL_W      = 1
);
   logic [NUM_DIGITS-1:0] digit_en;
   logic [SEL_W-1:0]      sel;
   logic [NUM_DIGITS-1:0] control;
   logic                  frame_tick;
   modport master (output digit_en, input sel, control, frame_tick);
   modport slave  (input digit_en, output sel, control, frame_tick);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: blanked time-multiplexed scan of a common-anode seven-segment bank
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 2,
   parameter int SEL_W        = 1,
   parameter int DWELL_CYCLES = 100000,
   parameter int BLANK_CYCLES = 2000,
   parameter int CNT_W        = 17
) (
   input  logic               clk,
   input  logic               reset,
   display_scan_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [SEL_W-1:0]      r_sel;
   logic [NUM_DIGITS-1:0] r_control;
   logic                  r_tick;
   logic [NUM_DIGITS-1:0] w_rot;
   logic [SEL_W-1:0]      w_first;
   logic [SEL_W-1:0]      w_off;
   logic [SEL_W-1:0]      w_nxt;
   logic [SEL_W:0]        w_sum;
   logic                  w_any;
   logic                  w_last;

   // lowest enabled digit, and first enabled digit after r_sel found on a rotated copy of the enables
   always_comb begin
      w_any   = |bus.digit_en;
      w_rot   = NUM_DIGITS'({bus.digit_en, bus.digit_en} >> ({1'b0, r_sel} + 1'b1));
      w_first = '0;
      w_off   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (bus.digit_en[i]) w_first = SEL_W'(i);
         if (w_rot[i]) w_off = SEL_W'(i);
      end
      w_sum  = {1'b0, r_sel} + {1'b0, w_off} + 1'b1;
      w_nxt  = (w_sum >= (SEL_W+1)'(NUM_DIGITS)) ? SEL_W'(w_sum - (SEL_W+1)'(NUM_DIGITS)) : w_sum[SEL_W-1:0];
      w_last = (r_cnt == CNT_W'(DWELL_CYCLES - 1)) || !bus.digit_en[r_sel];
   end

   // scan sequencer: sel only moves while all anodes are dark, lit anode follows the blank
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sel     <= '0;
         r_control <= '1;
         r_tick    <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            IDLE: if (w_any) begin
               r_sel   <= w_first;
               r_cnt   <= '0;
               r_tick  <= 1'b1;
               r_state <= BLANK;
            end
            BLANK: if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
               r_cnt     <= '0;
               r_control <= ~(NUM_DIGITS'(1) << r_sel);
               r_state   <= ON;
            end else r_cnt <= r_cnt + 1'b1;
            ON: if (w_last) begin
               r_control <= '1;
               r_cnt     <= '0;
               if (w_any) begin
                  r_sel   <= w_nxt;
                  r_tick  <= (w_nxt <= r_sel);
                  r_state <= BLANK;
               end else r_state <= IDLE;
            end else r_cnt <= r_cnt + 1'b1;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sel        = r_sel;
   assign bus.control    = r_control;
   assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scan scenarios checked against a cycle model through an expectation queue
module tb_display_scan_ctrl;
   localparam int N  = 2;
   localparam int SW = 1;
   localparam int DW = 8;
   localparam int BL = 2;

   typedef struct packed {
      logic [SW-1:0] sel;
      logic [N-1:0]  control;
      logic          tick;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   exp_t q[$];
   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_tick = -1;
   int period = 0;
   int m_state = 0;
   int m_left = 0;
   logic [SW-1:0] m_sel = '0;
   logic m_tick = 1'b0;
   logic [SW-1:0] prev_sel = '0;

   always #5 clk = ~clk;

   display_scan_ctrl_if #(.NUM_DIGITS(N), .SEL_W(SW)) bus ();

   display_scan_ctrl #(
      .NUM_DIGITS(N), .SEL_W(SW), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_left  = 0;
      m_sel   = '0;
      m_tick  = 1'b0;
      prev_sel = '0;
      q.delete();
   endtask

   // advances the reference by one clock using the enables present at that edge
   task automatic model_next();
      logic [N-1:0] en;
      int nxt;
      en = bus.digit_en;
      m_tick = 1'b0;
      nxt = -1;
      case (m_state)
         0: if (en != '0) begin
            for (int i = N - 1; i >= 0; i--) if (en[i]) m_sel = SW'(i);
            m_left  = BL;
            m_state = 1;
            m_tick  = 1'b1;
         end
         1: begin
            m_left--;
            if (m_left == 0) begin
               m_state = 2;
               m_left  = DW;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0 || !en[m_sel]) begin
               if (en == '0) m_state = 0;
               else begin
                  for (int k = N; k >= 1; k--) if (en[(int'(m_sel) + k) % N]) nxt = (int'(m_sel) + k) % N;
                  m_tick  = (nxt <= int'(m_sel));
                  m_sel   = SW'(nxt);
                  m_state = 1;
                  m_left  = BL;
               end
            end
         end
      endcase
   endtask

   task automatic step();
      exp_t e;
      model_next();
      q.push_back('{m_sel, (m_state == 2) ? ~(N'(1) << m_sel) : {N{1'b1}}, m_tick});
      @(posedge clk);
      #1;
      cyc++;
      e = q.pop_front();
      chk("sel", 8'(bus.sel), 8'(e.sel));
      chk("control", 8'(bus.control), 8'(e.control));
      chk("frame_tick", 8'(bus.frame_tick), 8'(e.tick));
      chk("one_anode_max", 8'($countones(~bus.control) <= 1), 8'd1);
      if (bus.sel != prev_sel) chk("sel_change_blanked", 8'(bus.control), 8'h3);
      prev_sel = bus.sel;
      if (bus.frame_tick) begin
         if (period != 0 && last_tick >= 0) chk("tick_period", 8'(cyc - last_tick), 8'(period));
         last_tick = cyc;
      end
   endtask

   initial begin
      bus.digit_en = 2'b11;
      // reset held with digits enabled: all anodes dark
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_control", 8'(bus.control), 8'h3);
         chk("rst_sel", 8'(bus.sel), 8'h0);
         chk("rst_tick", 8'(bus.frame_tick), 8'h0);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("idle_control", 8'(bus.control), 8'h3);
      chk("idle_tick", 8'(bus.frame_tick), 8'h0);
      period = 20;
      repeat (22) step();
      // steady two-digit scan
      repeat (100) step();
      // single digit 1
      bus.digit_en = 2'b10;
      period = 0;
      repeat (15) step();
      period = 10;
      last_tick = -1;
      repeat (40) begin
         step();
         chk("digit0_dark", 8'(bus.control[0]), 8'h1);
      end
      // early abort of digit 1 in its third lit cycle
      bus.digit_en = 2'b11;
      period = 0;
      for (int i = 0; i < 60; i++) begin
         if (m_state == 2 && m_sel == 1'b1 && m_left == DW - 2) break;
         step();
      end
      chk("reach_d1_cycle3", 8'(m_state == 2 && m_sel == 1'b1 && m_left == DW - 2), 8'h1);
      bus.digit_en = 2'b01;
      step();
      chk("abort_sel", 8'(bus.sel), 8'h0);
      chk("abort_tick", 8'(bus.frame_tick), 8'h1);
      chk("abort_blank", 8'(bus.control), 8'h3);
      repeat (40) begin
         step();
         chk("digit1_dark", 8'(bus.control[1]), 8'h1);
      end
      // all digits disabled mid-dwell, then re-enabled
      bus.digit_en = 2'b11;
      for (int i = 0; i < 30; i++) begin
         if (m_state == 2) break;
         step();
      end
      chk("reach_on", 8'(m_state), 8'd2);
      bus.digit_en = 2'b00;
      step();
      chk("off_control", 8'(bus.control), 8'h3);
      repeat (3) step();
      bus.digit_en = 2'b10;
      step();
      chk("reenable_sel", 8'(bus.sel), 8'h1);
      chk("reenable_tick", 8'(bus.frame_tick), 8'h1);
      // asynchronous reset between edges during a lit digit
      bus.digit_en = 2'b11;
      for (int i = 0; i < 40; i++) begin
         if (m_state == 2 && m_left == DW - 3) break;
         step();
      end
      chk("reach_on_mid", 8'(m_state == 2 && m_left == DW - 3), 8'h1);
      chk("lit_before_reset", 8'($countones(~bus.control)), 8'h1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_control", 8'(bus.control), 8'h3);
      chk("async_sel", 8'(bus.sel), 8'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      period = 20;
      last_tick = -1;
      repeat (22) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
